// File: rtl/ahb5_random_wait_subordinate.sv
// AHB5 subordinate over a word-addressed SRAM model, with LFSR-driven random wait states.
// Latency: data phase ends 1 + W cycles after the address phase (W = 0..MAX_WAIT); ERROR is always 2 cycles.
// Backpressure: HREADYOUT low during random waits and the first ERROR cycle; address inputs ignored while HREADY is low.
//
// Ports:
//   HCLK, HRESET         clock and synchronous active-high reset
//   HSEL, HADDR, HWRITE  address-phase select, byte address, direction
//   HSIZE, HBURST, HPROT address-phase size (0..2 legal), burst/protection (ignored)
//   HTRANS, HREADY       transfer type (bit 1 = NONSEQ/SEQ), muxed bus ready
//   HWDATA               write data, sampled in the final data-phase cycle
//   HREADYOUT, HRESP     this subordinate's ready and OKAY(0)/ERROR(1) response
//   HRDATA               read data, non-zero only in the final OKAY cycle of a read

module ahb5_random_wait_subordinate #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned MAX_WAIT = 3,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned     AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam longint unsigned LIMIT = 64'(DEPTH) * 64'd4;
    localparam logic [4:0]      MODV  = 5'(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_lfsr;
    logic [15:0]     w_lfsr_nxt;
    logic [3:0]      r_wcnt;
    logic [3:0]      w_wcnt_nxt;
    logic            r_dp_vld;      // a legal transfer owns the current data phase
    logic            w_dp_vld_nxt;
    logic            r_write;
    logic [1:0]      r_size;
    logic [1:0]      r_lane;
    logic [AW-1:0]   r_word;
    logic [31:0]     r_mem [DEPTH];

    logic            w_accept;
    logic            w_take;
    logic            w_err;
    logic            w_err_range;
    logic            w_err_size;
    logic            w_err_align;
    logic [3:0]      w_wait;
    logic            w_final;
    logic            w_wr_commit;
    logic [3:0]      w_be;
    logic            w_unused;

    // Burst type, protection and the SEQ/NONSEQ distinction carry no meaning here.
    assign w_unused = ^{HBURST, HPROT, HTRANS[0]};

    //--------------------------------------------------------------------
    // Address-phase decode
    //--------------------------------------------------------------------
    assign w_accept    = HSEL & HREADY & HTRANS[1];
    // Only IDLE and ERR2 can start a new transfer; in WAIT/ERR1 the bus
    // HREADY is low anyway, so this just hardens against a stray HREADY.
    assign w_take      = w_accept & ((r_state == ST_IDLE) | (r_state == ST_ERR2));

    assign w_err_range = (64'(HADDR) >= LIMIT);
    assign w_err_size  = (HSIZE > 3'd2);
    assign w_err_align = ((HSIZE == 3'd1) & HADDR[0]) |
                         ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
    assign w_err       = w_err_range | w_err_size | w_err_align;

    // Wait count drawn from the current LFSR value at the accepting edge.
    assign w_wait      = 4'({1'b0, r_lfsr[3:0]} % MODV);

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    assign w_lfsr_nxt  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    //--------------------------------------------------------------------
    // Data-phase status
    //--------------------------------------------------------------------
    // The final OKAY cycle is IDLE with a legal transfer still outstanding.
    assign w_final     = (r_state == ST_IDLE) & r_dp_vld;
    assign w_wr_commit = w_final & r_write;

    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            2'd0:    w_be = 4'b0001 << r_lane;
            2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    //--------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state  <= ST_IDLE;
            r_wcnt   <= 4'd0;
            r_dp_vld <= 1'b0;
            r_lfsr   <= SEED;
        end else begin
            r_state  <= w_state_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_dp_vld <= w_dp_vld_nxt;
            r_lfsr   <= w_lfsr_nxt;
        end
    end

    //--------------------------------------------------------------------
    // FSM: next state and handshake outputs
    //--------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_wcnt_nxt   = r_wcnt;
        w_dp_vld_nxt = r_dp_vld;
        HREADYOUT    = 1'b1;
        HRESP        = 1'b0;

        case (r_state)
            ST_IDLE, ST_ERR2: begin
                HRESP        = (r_state == ST_ERR2);
                w_state_nxt  = ST_IDLE;
                w_dp_vld_nxt = 1'b0;
                if (w_take) begin
                    if (w_err) begin
                        // Errors never take random waits.
                        w_state_nxt = ST_ERR1;
                    end else begin
                        w_dp_vld_nxt = 1'b1;
                        if (w_wait != 4'd0) begin
                            w_state_nxt = ST_WAIT;
                            w_wcnt_nxt  = w_wait;
                        end
                    end
                end
            end

            ST_WAIT: begin
                HREADYOUT = 1'b0;
                // Leaving on the last wait cycle makes the next cycle the
                // final one, so exactly W low cycles are seen.
                if (r_wcnt <= 4'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_wcnt_nxt  = 4'd0;
                end else begin
                    w_wcnt_nxt  = 4'(r_wcnt - 4'd1);
                end
            end

            ST_ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = 1'b1;
                w_state_nxt = ST_ERR2;
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_dp_vld_nxt = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------
    // Captured address-phase attributes
    //--------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_write <= 1'b0;
            r_size  <= 2'd0;
            r_lane  <= 2'd0;
            r_word  <= '0;
        end else if (w_take) begin
            r_write <= HWRITE;
            r_size  <= HSIZE[1:0];
            r_lane  <= HADDR[1:0];
            r_word  <= HADDR[AW+1:2];
        end
    end

    //--------------------------------------------------------------------
    // SRAM model (contents survive reset)
    //--------------------------------------------------------------------
    // A write lands on the same edge that accepts a following read, and the
    // read port is combinational, so a read of the same word in the very next
    // data phase already sees the merged data.
    always_ff @(posedge HCLK) begin
        if (!HRESET && w_wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_word][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        HRDATA = 32'h0000_0000;
        if (w_final && !r_write) begin
            HRDATA = r_mem[r_word];
        end
    end

endmodule

// File: tb/tb_ahb5_random_wait_subordinate.sv
// Bench for ahb5_random_wait_subordinate: two instances, bus 0 with MAX_WAIT=0
// (directed table) and bus 1 with MAX_WAIT=3 (random traffic and reset abort).
// Expectations are queued when an address phase is driven and checked when the data phase ends.

module tb_ahb5_random_wait_subordinate;

    logic             clk;
    logic [1:0]       hreset;
    logic [1:0]       hsel;
    logic [1:0]       hwrite;
    logic [1:0][31:0] haddr;
    logic [1:0][31:0] hwdata;
    logic [1:0][2:0]  hsize;
    logic [1:0][2:0]  hburst;
    logic [1:0][3:0]  hprot;
    logic [1:0][1:0]  htrans;
    wire  [1:0]       hreadyout;
    wire  [1:0]       hresp;
    wire  [1:0][31:0] hrdata;

    ahb5_random_wait_subordinate #(.DEPTH(1024), .MAX_WAIT(0), .SEED(16'hACE1)) u_dut0 (
        .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HPROT(hprot[0]),
        .HTRANS(htrans[0]), .HWDATA(hwdata[0]), .HREADY(hreadyout[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    ahb5_random_wait_subordinate #(.DEPTH(1024), .MAX_WAIT(3), .SEED(16'hACE1)) u_dut1 (
        .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HPROT(hprot[1]),
        .HTRANS(htrans[1]), .HWDATA(hwdata[1]), .HREADY(hreadyout[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        err;
        bit [31:0] rd;
        string     nm;
    } exp_t;

    typedef struct {
        bit        wr;
        bit [2:0]  sz;
        bit [31:0] addr;
        bit [31:0] wd;
        bit        err;
        bit [31:0] rd;
        int        idle;
        string     nm;
    } vec_t;

    exp_t      q0[$];
    exp_t      q1[$];
    int        n_chk  = 0;
    int        n_pass = 0;
    int        hist[4];
    bit [31:0] mdl[64];
    vec_t      tbl[20];

    function automatic void chk(bit ok, string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, got, exp);
    endfunction

    // Byte b of the word is written when it lies inside [off, off + 2**sz).
    function automatic bit lane_hit(bit [2:0] sz, bit [1:0] off, int b);
        int lo = int'(off);
        int hi = lo + (1 << sz);
        return (b >= lo) && (b < hi);
    endfunction

    //------------------------------------------------------------------
    // Data-phase monitor / scoreboard
    //------------------------------------------------------------------
    bit [1:0] act, lowr0, lowr1, badrd;
    int       wt[2];
    exp_t     me;
    bit       have;
    int       maxw;

    initial begin
        act = '0;
        for (int i = 0; i < 4; i++) hist[i] = 0;
    end

    always @(negedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (hreset[b]) begin
                act[b] = 1'b0;
                if (b == 0) q0.delete(); else q1.delete();
            end else begin
                if (act[b]) begin
                    if (!hreadyout[b]) begin
                        wt[b]++;
                        if (hresp[b]) lowr1[b] = 1'b1; else lowr0[b] = 1'b1;
                        if (hrdata[b] != 32'h0) badrd[b] = 1'b1;
                    end else begin
                        have = (b == 0) ? (q0.size() > 0) : (q1.size() > 0);
                        chk(have, "sb_nonempty", 32'(have), 32'd1);
                        if (have) begin
                            me   = (b == 0) ? q0.pop_front() : q1.pop_front();
                            maxw = (b == 0) ? 0 : 3;
                            chk(hresp[b] == me.err, {me.nm, "_hresp"}, 32'(hresp[b]), 32'(me.err));
                            chk(hrdata[b] == me.rd, {me.nm, "_hrdata"}, hrdata[b], me.rd);
                            chk(!badrd[b], {me.nm, "_hrdata_wait"}, 32'(badrd[b]), 32'd0);
                            if (me.err) begin
                                chk(wt[b] == 1 && lowr1[b] && !lowr0[b], {me.nm, "_err_cycles"},
                                    32'(wt[b]), 32'd1);
                            end else begin
                                chk(wt[b] <= maxw && !lowr1[b], {me.nm, "_waits"},
                                    32'(wt[b]), 32'(maxw));
                                if (b == 1 && wt[b] < 4) hist[wt[b]]++;
                            end
                        end
                        act[b] = 1'b0;
                    end
                end
                if (hsel[b] && hreadyout[b] && htrans[b][1]) begin
                    act[b]   = 1'b1;
                    wt[b]    = 0;
                    lowr0[b] = 1'b0;
                    lowr1[b] = 1'b0;
                    badrd[b] = 1'b0;
                end
            end
        end
    end

    //------------------------------------------------------------------
    // Bus driver tasks (inputs change 1 time unit after the rising edge)
    //------------------------------------------------------------------
    task automatic wait_accept(int b);
        int n = 0;
        @(negedge clk);
        while (!hreadyout[b] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk(1'b0, "accept_timeout", 32'(n), 32'd50);
        @(posedge clk);
        #1;
    endtask

    // Drives one address phase, returns at the start of its data phase with
    // the bus idle and HWDATA set, so a following call pipelines naturally.
    task automatic xfer(int b, bit wr, bit [2:0] sz, bit [31:0] a, bit [31:0] wd,
                        bit err, bit [31:0] rd, string nm);
        exp_t e;
        hsel[b]   = 1'b1;
        htrans[b] = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
        haddr[b]  = a;
        hwrite[b] = wr;
        hsize[b]  = sz;
        hburst[b] = 3'($urandom_range(0, 7));
        hprot[b]  = 4'($urandom_range(0, 15));
        e.err = err;
        e.rd  = (err || wr) ? 32'h0 : rd;
        e.nm  = nm;
        if (b == 0) q0.push_back(e); else q1.push_back(e);
        wait_accept(b);
        hwdata[b] = wd;
        hsel[b]   = 1'b0;
        htrans[b] = 2'b00;
    endtask

    // Non-transfer cycles: plain idle, selected BUSY, selected IDLE, or an unselected NONSEQ.
    task automatic idle(int b, int n, int mode);
        case (mode)
            1:       begin hsel[b] = 1'b1; htrans[b] = 2'b01; end
            2:       begin hsel[b] = 1'b1; htrans[b] = 2'b00; end
            3:       begin hsel[b] = 1'b0; htrans[b] = 2'b10; end
            default: begin hsel[b] = 1'b0; htrans[b] = 2'b00; end
        endcase
        haddr[b]  = $urandom;
        hwrite[b] = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        hsel[b]   = 1'b0;
        htrans[b] = 2'b00;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    //------------------------------------------------------------------
    // Test sequence
    //------------------------------------------------------------------
    bit        wr, err, found;
    bit [2:0]  sz;
    bit [1:0]  off;
    bit [31:0] a, wd, erd;
    int        w;

    initial begin
        tbl[0]  = '{1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        1, "t1_wr"};
        tbl[1]  = '{1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 1, "t1_rd"};
        tbl[2]  = '{1'b1, 3'd2, 32'h10,   32'h11223344, 1'b0, 32'h0,        1, "t2_wr_word"};
        tbl[3]  = '{1'b1, 3'd0, 32'h13,   32'hAAAAAAAA, 1'b0, 32'h0,        1, "t2_wr_byte"};
        tbl[4]  = '{1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'hAA223344, 1, "t2_rd"};
        tbl[5]  = '{1'b1, 3'd2, 32'h20,   32'h00000005, 1'b0, 32'h0,        0, "t3_wr"};
        tbl[6]  = '{1'b0, 3'd2, 32'h20,   32'h0,        1'b0, 32'h00000005, 1, "t3_rd_fwd"};
        tbl[7]  = '{1'b0, 3'd2, 32'h1000, 32'h0,        1'b1, 32'h0,        0, "t4_range"};
        tbl[8]  = '{1'b0, 3'd2, 32'h2,    32'h0,        1'b1, 32'h0,        0, "t4_align"};
        tbl[9]  = '{1'b0, 3'd3, 32'h10,   32'h0,        1'b1, 32'h0,        0, "t4_size"};
        tbl[10] = '{1'b1, 3'd2, 32'h12,   32'hFFFFFFFF, 1'b1, 32'h0,        0, "t4_wr_align"};
        tbl[11] = '{1'b1, 3'd1, 32'h11,   32'hFFFFFFFF, 1'b1, 32'h0,        0, "t4_wr_half"};
        tbl[12] = '{1'b1, 3'd2, 32'h1004, 32'hFFFFFFFF, 1'b1, 32'h0,        0, "t4_wr_range"};
        tbl[13] = '{1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'hAA223344, 0, "t4_unchanged"};
        tbl[14] = '{1'b1, 3'd1, 32'h22,   32'hBEEF1234, 1'b0, 32'h0,        0, "hw_wr"};
        tbl[15] = '{1'b0, 3'd2, 32'h20,   32'h0,        1'b0, 32'hBEEF0005, 0, "hw_rd"};
        tbl[16] = '{1'b0, 3'd0, 32'h23,   32'h0,        1'b0, 32'hBEEF0005, 1, "rd_byte_word"};
        tbl[17] = '{1'b0, 3'd1, 32'h12,   32'h0,        1'b0, 32'hAA223344, 1, "rd_half_word"};
        tbl[18] = '{1'b1, 3'd2, 32'hFFC,  32'h13579BDF, 1'b0, 32'h0,        0, "top_wr"};
        tbl[19] = '{1'b0, 3'd2, 32'hFFC,  32'h0,        1'b0, 32'h13579BDF, 2, "top_rd"};

        hreset = 2'b11;
        hsel   = '0;
        hwrite = '0;
        haddr  = '0;
        hwdata = '0;
        hsize  = '0;
        hburst = '0;
        hprot  = '0;
        htrans = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            chk(hreadyout[b] == 1'b1, "reset_hreadyout", 32'(hreadyout[b]), 32'd1);
            chk(hresp[b] == 1'b0, "reset_hresp", 32'(hresp[b]), 32'd0);
            chk(hrdata[b] == 32'h0, "reset_hrdata", hrdata[b], 32'h0);
        end
        @(posedge clk);
        #1;
        hreset = 2'b00;

        // Bus 0: directed table, zero-wait subordinate.
        for (int i = 0; i < 20; i++) begin
            xfer(0, tbl[i].wr, tbl[i].sz, tbl[i].addr, tbl[i].wd, tbl[i].err, tbl[i].rd, tbl[i].nm);
            if (tbl[i].idle > 0) idle(0, tbl[i].idle, i % 4);
        end
        idle(0, 4, 0);

        // Bus 1: fill a 64-word window, then random traffic.
        for (int i = 0; i < 64; i++) begin
            wd     = $urandom;
            mdl[i] = wd;
            xfer(1, 1'b1, 3'd2, 32'(i * 4), wd, 1'b0, 32'h0, "fill");
        end

        for (int n = 0; n < 200; n++) begin
            wr  = 1'($urandom_range(0, 1));
            sz  = 3'($urandom_range(0, 2));
            w   = $urandom_range(0, 63);
            off = (sz == 3'd0) ? 2'($urandom_range(0, 3)) :
                  (sz == 3'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            a   = 32'(w * 4) + 32'(off);
            wd  = $urandom;
            err = 1'b0;
            case ($urandom_range(0, 11))
                0: begin a = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4; err = 1'b1; end
                1: begin sz = 3'($urandom_range(3, 7)); err = 1'b1; end
                2: if (sz != 3'd0) begin a = a | 32'd1; err = 1'b1; end
                default: ;
            endcase
            erd = 32'h0;
            if (!err && wr) begin
                for (int b = 0; b < 4; b++)
                    if (lane_hit(sz, off, b)) mdl[w][8*b +: 8] = wd[8*b +: 8];
            end else if (!err) begin
                erd = mdl[w];
            end
            xfer(1, wr, sz, a, wd, err, erd, "rand");
            idle(1, $urandom_range(0, 2), $urandom_range(0, 3));
        end
        idle(1, 6, 0);

        for (int i = 0; i < 4; i++)
            chk(hist[i] > 0, "wait_count_seen", 32'(i), 32'(hist[i]));

        // Reset while a write to 0x40 (word 16) is in its wait states.
        found = 1'b0;
        for (int t = 0; t < 30 && !found; t++) begin
            hsel[1]   = 1'b1;
            htrans[1] = 2'b10;
            haddr[1]  = 32'h40;
            hwrite[1] = 1'b1;
            hsize[1]  = 3'd2;
            q1.push_back('{1'b0, 32'h0, "t6_wr_try"});
            wait_accept(1);
            hsel[1]   = 1'b0;
            htrans[1] = 2'b00;
            hwdata[1] = ~mdl[16];
            @(negedge clk);
            #1;
            if (hreadyout[1]) begin
                // Zero-wait attempt: rewrite the old contents so memory is unchanged.
                hwdata[1] = mdl[16];
                @(posedge clk);
                #1;
            end else begin
                found     = 1'b1;
                hreset[1] = 1'b1;
                @(posedge clk);
                #1;
                @(negedge clk);
                chk(hreadyout[1] == 1'b1, "t6_rst_hreadyout", 32'(hreadyout[1]), 32'd1);
                chk(hresp[1] == 1'b0, "t6_rst_hresp", 32'(hresp[1]), 32'd0);
                chk(hrdata[1] == 32'h0, "t6_rst_hrdata", hrdata[1], 32'h0);
                @(posedge clk);
                #1;
                hreset[1] = 1'b0;
            end
        end
        chk(found, "t6_wait_reached", 32'(found), 32'd1);
        idle(1, 1, 0);
        xfer(1, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0, mdl[16], "t6_rd_old");
        idle(1, 6, 0);

        chk(q0.size() == 0, "q0_drained", 32'(q0.size()), 32'd0);
        chk(q1.size() == 0, "q1_drained", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
